// File: rtl/vx_async_barrier_table_pkg.sv
// Shared types for the warp-control barrier table.
// Entry widths are fixed here so the entry struct can be passed between modules.
package vx_async_barrier_table_pkg;

    localparam int BAR_NUM_WARPS = 8;
    localparam int BAR_NW_W      = (BAR_NUM_WARPS > 1) ? $clog2(BAR_NUM_WARPS) : 1;
    localparam int BAR_CNT_W     = 8;
    localparam int BAR_TOKEN_W   = 32;

    typedef enum logic [1:0] {
        BAR_INIT        = 2'd0,
        BAR_ARRIVE      = 2'd1,
        BAR_WAIT        = 2'd2,
        BAR_ARRIVE_WAIT = 2'd3
    } bar_op_t;

    typedef struct packed {
        logic [BAR_CNT_W-1:0]     expected;
        logic [BAR_CNT_W-1:0]     arrived;
        logic [BAR_TOKEN_W-1:0]   gen;
        logic [BAR_NUM_WARPS-1:0] wait_mask;
    } bar_entry_t;

endpackage

// File: rtl/vx_bar_entry_update.sv
// Combinational next-state of one barrier entry for a single op.
// An entry with expected==0 is uninitialised and ignores arrivals.
module vx_bar_entry_update
    import vx_async_barrier_table_pkg::*;
(
    input  bar_entry_t                entry_i,
    input  bar_op_t                   op_i,
    input  logic [BAR_NW_W-1:0]       wid_i,
    input  logic [BAR_CNT_W-1:0]      count_i,
    input  logic [BAR_TOKEN_W-1:0]    token_i,
    output bar_entry_t                entry_o,
    output logic [BAR_NUM_WARPS-1:0]  release_o,
    output logic                      phase_done_o
);

    logic [BAR_NUM_WARPS-1:0] wid_bit;
    logic [BAR_CNT_W:0]       arr_inc;
    logic                     is_init;
    logic                     completes;

    assign wid_bit   = BAR_NUM_WARPS'(1) << wid_i;
    assign arr_inc   = {1'b0, entry_i.arrived} + 1'b1;
    assign is_init   = (entry_i.expected != '0);
    assign completes = is_init && (arr_inc == {1'b0, entry_i.expected});

    always_comb begin
        entry_o      = entry_i;
        release_o    = '0;
        phase_done_o = 1'b0;
        unique case (op_i)
            BAR_INIT: begin
                entry_o.expected  = (count_i == '0) ? BAR_CNT_W'(1) : count_i;
                entry_o.arrived   = '0;
                entry_o.wait_mask = '0;
                release_o         = entry_i.wait_mask;
            end
            BAR_ARRIVE, BAR_ARRIVE_WAIT: begin
                if (completes) begin
                    entry_o.gen       = entry_i.gen + 1'b1;
                    entry_o.arrived   = '0;
                    entry_o.wait_mask = '0;
                    phase_done_o      = 1'b1;
                    release_o         = entry_i.wait_mask;
                    if (op_i == BAR_ARRIVE_WAIT) begin
                        release_o = entry_i.wait_mask | wid_bit;
                    end
                end else if (is_init) begin
                    entry_o.arrived = arr_inc[BAR_CNT_W-1:0];
                    if (op_i == BAR_ARRIVE_WAIT) begin
                        entry_o.wait_mask = entry_i.wait_mask | wid_bit;
                    end
                end
            end
            BAR_WAIT: begin
                if (token_i == entry_i.gen) begin
                    entry_o.wait_mask = entry_i.wait_mask | wid_bit;
                end else begin
                    release_o = wid_bit;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vx_async_barrier_table.sv
// Barrier table: entry array, IDLE/RELEASE handshake FSM, release register.
// Optional saturating perf counters under VX_BAR_PERF_EN.
module vx_async_barrier_table
    import vx_async_barrier_table_pkg::*;
#(
    parameter int NUM_WARPS    = BAR_NUM_WARPS,
    parameter int NUM_BARRIERS = 16,
    parameter int CNT_W        = BAR_CNT_W,
    parameter int TOKEN_W      = BAR_TOKEN_W,
    parameter int PERF_W       = 44,
    localparam int NB_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  bar_op_t              req_op,
    input  logic [NW_W-1:0]      req_wid,
    input  logic [NB_W-1:0]      req_bar_id,
    input  logic [CNT_W-1:0]     req_count,
    input  logic [TOKEN_W-1:0]   req_token,
    input  logic [NB_W-1:0]      barrier_id_rd,
    output logic [TOKEN_W-1:0]   arrive_token,
    output logic                 rel_valid,
    input  logic                 rel_ready,
    output logic [NUM_WARPS-1:0] rel_mask,
    output logic [PERF_W-1:0]    perf_phases,
    output logic [PERF_W-1:0]    perf_stalls
);

    typedef enum logic {ST_IDLE, ST_RELEASE} state_e;

    state_e                 state_q, state_d;
    logic                   rel_valid_q, rel_valid_d;
    logic [NUM_WARPS-1:0]   rel_mask_q, rel_mask_d;
    bar_entry_t             entries_q [NUM_BARRIERS];
    bar_entry_t             entries_d [NUM_BARRIERS];

    bar_entry_t             upd_entry;
    logic [NUM_WARPS-1:0]   upd_rel;
    logic                   upd_phase_done;
    logic                   accept;

    assign req_ready    = (state_q == ST_IDLE);
    assign accept       = req_valid && req_ready;
    assign arrive_token = entries_q[barrier_id_rd].gen;
    assign rel_valid    = rel_valid_q;
    assign rel_mask     = rel_mask_q;

    vx_bar_entry_update u_upd (
        .entry_i      (entries_q[req_bar_id]),
        .op_i         (req_op),
        .wid_i        (req_wid),
        .count_i      (req_count),
        .token_i      (req_token),
        .entry_o      (upd_entry),
        .release_o    (upd_rel),
        .phase_done_o (upd_phase_done)
    );

    always_comb begin
        state_d     = state_q;
        rel_valid_d = rel_valid_q;
        rel_mask_d  = rel_mask_q;
        entries_d   = entries_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    entries_d[req_bar_id] = upd_entry;
                    if (upd_rel != '0) begin
                        state_d     = ST_RELEASE;
                        rel_valid_d = 1'b1;
                        rel_mask_d  = upd_rel;
                    end
                end
            end
            ST_RELEASE: begin
                if (rel_ready) begin
                    state_d     = ST_IDLE;
                    rel_valid_d = 1'b0;
                    rel_mask_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rel_valid_q <= 1'b0;
            rel_mask_q  <= '0;
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rel_valid_q <= rel_valid_d;
            rel_mask_q  <= rel_mask_d;
            entries_q   <= entries_d;
        end
    end

`ifdef VX_BAR_PERF_EN
    logic [PERF_W-1:0] perf_phases_q, perf_phases_d;
    logic [PERF_W-1:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_phases_d = perf_phases_q;
        perf_stalls_d = perf_stalls_q;
        if (accept && upd_phase_done && !(&perf_phases_q)) begin
            perf_phases_d = perf_phases_q + 1'b1;
        end
        if (req_valid && !req_ready && !(&perf_stalls_q)) begin
            perf_stalls_d = perf_stalls_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_phases_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_phases_q <= perf_phases_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_phases = perf_phases_q;
    assign perf_stalls = perf_stalls_q;
`else
    logic unused_phase_done;
    assign unused_phase_done = upd_phase_done;
    assign perf_phases = '0;
    assign perf_stalls = '0;
`endif

endmodule
